dict_lookup_bank: RTL and testbench



---
 rtl/dict_pkg.sv | 39 +++
 rtl/dict_ram.sv | 80 ++++++++
 rtl/dict_lookup_bank.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_dict_lookup_bank.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dict_pkg.sv
// ---------------------------------------------------------------------------
// dict_pkg
// Shared types and helpers for the dictionary lookup bank.
//   state_t        : bank phase (LOAD -> SERVE -> DRAIN -> LOAD)
//   load_mode_t    : how a load beat picks its target index
//   result_t       : one lookup result at the default widths (32-bit value,
//                    10-bit tag); the bank itself uses a locally sized copy
//   min_fifo_depth : smallest legal output buffer for a given RAM latency
// ---------------------------------------------------------------------------
package dict_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SERVE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef enum logic {
        SEQ  = 1'b0,
        ADDR = 1'b1
    } load_mode_t;

    localparam int DEF_VALUE_W = 32;
    localparam int DEF_TAG_W   = 10;

    typedef struct packed {
        logic [DEF_VALUE_W-1:0] value;
        logic [DEF_TAG_W-1:0]   tag;
        logic                   last;
        logic                   miss;
    } result_t;

    // The buffer must hold every read in flight plus a couple of results
    // that are waiting for downstream.
    function automatic int min_fifo_depth(input int lat);
        return lat + 2;
    endfunction

endpackage

// File: rtl/dict_ram.sv
// ---------------------------------------------------------------------------
// dict_ram
// Simple dual-port RAM, DEPTH x VALUE_W, with a registered request stage
// followed by READ_LATENCY read-data registers. A side-band word (tag, last,
// miss) travels down a parallel pipeline so it emerges aligned with the data.
// A read issued at edge t is presented on rd_valid/rd_data after edge
// t+READ_LATENCY.
// Ports:
//   clk, rst              clock, synchronous active-high reset (valid bits only)
//   wr_en/wr_addr/wr_data write port
//   rd_en/rd_addr/rd_sb   read request with side-band word
//   rd_valid/rd_data/rd_sb_out  aligned read result
// ---------------------------------------------------------------------------
module dict_ram #(
    parameter  int VALUE_W      = 32,
    parameter  int DEPTH        = 4096,
    parameter  int READ_LATENCY = 2,
    parameter  int SB_W         = 12,
    localparam int AW           = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [VALUE_W-1:0] wr_data,
    input  logic               rd_en,
    input  logic [AW-1:0]      rd_addr,
    input  logic [SB_W-1:0]    rd_sb,
    output logic               rd_valid,
    output logic [VALUE_W-1:0] rd_data,
    output logic [SB_W-1:0]    rd_sb_out
);

    logic [VALUE_W-1:0] mem [DEPTH];

    logic                    req_valid;
    logic [AW-1:0]           req_addr;
    logic [SB_W-1:0]         req_sb;
    logic [READ_LATENCY-1:0] pipe_valid;
    logic [VALUE_W-1:0]      pipe_data [READ_LATENCY];
    logic [SB_W-1:0]         pipe_sb   [READ_LATENCY];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Only the valid bits need a reset; data registers are qualified by them.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_valid  <= 1'b0;
            pipe_valid <= '0;
        end else begin
            req_valid     <= rd_en;
            pipe_valid[0] <= req_valid;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en) begin
            req_addr <= rd_addr;
            req_sb   <= rd_sb;
        end
        pipe_data[0] <= mem[req_addr];
        pipe_sb[0]   <= req_sb;
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_data[i] <= pipe_data[i-1];
            pipe_sb[i]   <= pipe_sb[i-1];
        end
    end

    assign rd_valid  = pipe_valid[READ_LATENCY-1];
    assign rd_data   = pipe_data[READ_LATENCY-1];
    assign rd_sb_out = pipe_sb[READ_LATENCY-1];

endmodule

// File: rtl/dict_lookup_bank.sv
// ---------------------------------------------------------------------------
// dict_lookup_bank
// Single-bank dictionary store. A load phase fills the RAM (sequential or
// addressed beats, freely mixed), a serve phase answers id lookups in order
// with the request tag passed through, and a drain phase waits for every
// accepted lookup to leave before returning to load.
//
// Optional build macro: DICT_VALID_BITMAP_EN
//   defined   : a per-entry valid bitmap decides misses, so holes left by
//               addressed loads read as misses
//   undefined : an id misses only when it is >= DEPTH or >= entries_o
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   load_valid/ready/mode/id/data/last   load stream
//   lookup_valid/ready/id/tag/last       lookup request stream
//   out_valid/ready/data/tag/last/miss   in-order result stream
//   state_o    current phase
//   entries_o  highest written index + 1 in this load phase
//   err_o      sticky: a load beat targeted an index >= DEPTH
// ---------------------------------------------------------------------------
module dict_lookup_bank
    import dict_pkg::*;
#(
    parameter  int VALUE_W      = 32,
    parameter  int ID_W         = 16,
    parameter  int TAG_W        = 10,
    parameter  int DEPTH        = 4096,
    parameter  int READ_LATENCY = 2,
    parameter  int FIFO_DEPTH   = 8,
    localparam int AW           = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_valid,
    output logic               load_ready,
    input  logic               load_mode,
    input  logic [ID_W-1:0]    load_id,
    input  logic [VALUE_W-1:0] load_data,
    input  logic               load_last,
    input  logic               lookup_valid,
    output logic               lookup_ready,
    input  logic [ID_W-1:0]    lookup_id,
    input  logic [TAG_W-1:0]   lookup_tag,
    input  logic               lookup_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [VALUE_W-1:0] out_data,
    output logic [TAG_W-1:0]   out_tag,
    output logic               out_last,
    output logic               out_miss,
    output logic [1:0]         state_o,
    output logic [AW:0]        entries_o,
    output logic               err_o
);

    // Common width able to hold any id, DEPTH and entries_o for comparisons.
    localparam int CW    = (ID_W > AW + 1) ? ID_W : AW + 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int SB_W  = TAG_W + 2;

    if (READ_LATENCY < 1) begin : g_bad_latency
        $error("dict_lookup_bank: READ_LATENCY must be at least 1");
    end
    if (FIFO_DEPTH < min_fifo_depth(READ_LATENCY)) begin : g_bad_fifo
        $error("dict_lookup_bank: FIFO_DEPTH must be at least READ_LATENCY+2");
    end

    typedef struct packed {
        logic [VALUE_W-1:0] value;
        logic [TAG_W-1:0]   tag;
        logic               last;
        logic               miss;
    } bank_result_t;

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  outstanding_q;
    logic [AW:0]       wr_ptr_q;
    logic [AW:0]       entries_q;
    logic              err_q;

    logic              load_fire;
    logic              lookup_fire;
    logic              out_fire;
    logic              drain_done;
    logic [CW-1:0]     load_addr;
    logic              load_in_range;
    logic              ram_wr_en;
    logic [CW-1:0]     lookup_ext;
    logic              lookup_miss;

    logic              ram_rd_valid;
    logic [VALUE_W-1:0] ram_rd_data;
    logic [SB_W-1:0]   ram_rd_sb;
    bank_result_t      ram_result;

    bank_result_t      fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]     fifo_rd_ptr_q;
    logic [PW-1:0]     fifo_wr_ptr_q;
    logic [CNT_W-1:0]  fifo_count_q;

    assign load_fire   = load_valid & load_ready;
    assign lookup_fire = lookup_valid & lookup_ready;
    assign out_fire    = out_valid & out_ready;
    assign drain_done  = (state_q == DRAIN) && (outstanding_q == '0);

    // -----------------------------------------------------------------------
    // Phase FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Credit check: every accepted lookup owns a FIFO slot until it leaves,
    // whether it is still in the RAM pipeline or already buffered.
    always_comb begin
        state_d      = state_q;
        load_ready   = 1'b0;
        lookup_ready = 1'b0;
        case (state_q)
            LOAD: begin
                load_ready = 1'b1;
                if (load_valid && load_last) begin
                    state_d = SERVE;
                end
            end
            SERVE: begin
                lookup_ready = (outstanding_q < CNT_W'(FIFO_DEPTH));
                if (lookup_valid && lookup_ready && lookup_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (outstanding_q == '0) begin
                    state_d = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // -----------------------------------------------------------------------
    // Load path
    // -----------------------------------------------------------------------
    always_comb begin
        load_addr = (load_mode_t'(load_mode) == ADDR) ? CW'(load_id) : CW'(wr_ptr_q);
    end

    assign load_in_range = (load_addr < CW'(DEPTH));
    assign ram_wr_en     = load_fire & load_in_range;

    // The sequential pointer saturates at DEPTH so overlong sequential loads
    // keep being dropped instead of wrapping back into range.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            entries_q <= '0;
            err_q     <= 1'b0;
        end else if (drain_done) begin
            wr_ptr_q  <= '0;
            entries_q <= '0;
        end else if (load_fire) begin
            if ((load_mode_t'(load_mode) == SEQ) && (wr_ptr_q != (AW+1)'(DEPTH))) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (!load_in_range) begin
                err_q <= 1'b1;
            end else if (load_addr >= CW'(entries_q)) begin
                entries_q <= load_addr[AW:0] + 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Miss decision at lookup accept
    // -----------------------------------------------------------------------
    assign lookup_ext = CW'(lookup_id);

`ifdef DICT_VALID_BITMAP_EN
    logic [DEPTH-1:0] bitmap_q;

    always_ff @(posedge clk) begin
        if (rst || drain_done) begin
            bitmap_q <= '0;
        end else if (ram_wr_en) begin
            bitmap_q[load_addr[AW-1:0]] <= 1'b1;
        end
    end

    assign lookup_miss = (lookup_ext >= CW'(DEPTH)) || !bitmap_q[lookup_ext[AW-1:0]];
`else
    assign lookup_miss = (lookup_ext >= CW'(DEPTH)) || (lookup_ext >= CW'(entries_q));
`endif

    // -----------------------------------------------------------------------
    // Outstanding-result credit counter
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding_q <= '0;
        end else begin
            case ({lookup_fire, out_fire})
                2'b10:   outstanding_q <= outstanding_q + 1'b1;
                2'b01:   outstanding_q <= outstanding_q - 1'b1;
                default: outstanding_q <= outstanding_q;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // RAM with aligned side-band
    // -----------------------------------------------------------------------
    dict_ram #(
        .VALUE_W      (VALUE_W),
        .DEPTH        (DEPTH),
        .READ_LATENCY (READ_LATENCY),
        .SB_W         (SB_W)
    ) u_ram (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (ram_wr_en),
        .wr_addr   (load_addr[AW-1:0]),
        .wr_data   (load_data),
        .rd_en     (lookup_fire),
        .rd_addr   (lookup_ext[AW-1:0]),
        .rd_sb     ({lookup_tag, lookup_last, lookup_miss}),
        .rd_valid  (ram_rd_valid),
        .rd_data   (ram_rd_data),
        .rd_sb_out (ram_rd_sb)
    );

    // A miss may have read an arbitrary or stale location, so force zero.
    always_comb begin
        ram_result.tag   = ram_rd_sb[SB_W-1:2];
        ram_result.last  = ram_rd_sb[1];
        ram_result.miss  = ram_rd_sb[0];
        ram_result.value = ram_rd_sb[0] ? '0 : ram_rd_data;
    end

    // -----------------------------------------------------------------------
    // Output FIFO; cannot overflow because of the credit counter
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_rd_ptr_q <= '0;
            fifo_wr_ptr_q <= '0;
            fifo_count_q  <= '0;
        end else begin
            if (ram_rd_valid) begin
                fifo_wr_ptr_q <= (fifo_wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : fifo_wr_ptr_q + 1'b1;
            end
            if (out_fire) begin
                fifo_rd_ptr_q <= (fifo_rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : fifo_rd_ptr_q + 1'b1;
            end
            case ({ram_rd_valid, out_fire})
                2'b10:   fifo_count_q <= fifo_count_q + 1'b1;
                2'b01:   fifo_count_q <= fifo_count_q - 1'b1;
                default: fifo_count_q <= fifo_count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (ram_rd_valid) begin
            fifo_mem[fifo_wr_ptr_q] <= ram_result;
        end
    end

    assign out_valid = (fifo_count_q != '0);
    assign out_data  = fifo_mem[fifo_rd_ptr_q].value;
    assign out_tag   = fifo_mem[fifo_rd_ptr_q].tag;
    assign out_last  = fifo_mem[fifo_rd_ptr_q].last;
    assign out_miss  = fifo_mem[fifo_rd_ptr_q].miss;

    assign state_o   = state_q;
    assign entries_o = entries_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_dict_lookup_bank.sv
// ---------------------------------------------------------------------------
// tb_dict_lookup_bank
// Directed bench for dict_lookup_bank at default parameters
// (VALUE_W=32, ID_W=16, TAG_W=10, DEPTH=4096, READ_LATENCY=2, FIFO_DEPTH=8).
// ---------------------------------------------------------------------------
module tb_dict_lookup_bank;
    import dict_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic        load_mode = 1'b0;
    logic [15:0] load_id = '0;
    logic [31:0] load_data = '0;
    logic        load_last = 1'b0;
    logic        lookup_valid = 1'b0;
    logic        lookup_ready;
    logic [15:0] lookup_id = '0;
    logic [9:0]  lookup_tag = '0;
    logic        lookup_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [9:0]  out_tag;
    logic        out_last;
    logic        out_miss;
    logic [1:0]  state_o;
    logic [12:0] entries_o;
    logic        err_o;

    int checks = 0;
    int failures = 0;

    result_t exp_q[$];
    result_t got_q[$];

    dict_lookup_bank dut (
        .clk          (clk),
        .rst          (rst),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .load_mode    (load_mode),
        .load_id      (load_id),
        .load_data    (load_data),
        .load_last    (load_last),
        .lookup_valid (lookup_valid),
        .lookup_ready (lookup_ready),
        .lookup_id    (lookup_id),
        .lookup_tag   (lookup_tag),
        .lookup_last  (lookup_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_tag      (out_tag),
        .out_last     (out_last),
        .out_miss     (out_miss),
        .state_o      (state_o),
        .entries_o    (entries_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    // Inputs settle 1 time unit after each rising edge, so the negative edge
    // sees exactly what the next rising edge will act on.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            result_t r;
            r.value = out_data;
            r.tag   = out_tag;
            r.last  = out_last;
            r.miss  = out_miss;
            got_q.push_back(r);
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", name, observed, expected);
        end
    endtask

    // One beat on the load (is_lookup=0) or lookup (is_lookup=1) interface.
    task automatic applyStimulus(input bit is_lookup, input logic mode, input logic [15:0] id,
                                 input logic [31:0] data_or_tag, input logic last);
        int waited = 0;
        if (is_lookup) begin
            lookup_id    = id;
            lookup_tag   = data_or_tag[9:0];
            lookup_last  = last;
            lookup_valid = 1'b1;
        end else begin
            load_mode  = mode;
            load_id    = id;
            load_data  = data_or_tag;
            load_last  = last;
            load_valid = 1'b1;
        end
        while (!(is_lookup ? lookup_ready : load_ready) && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!(is_lookup ? lookup_ready : load_ready)) begin
            checkOutput("handshake_timeout", 64'd0, 64'd1);
        end else begin
            @(posedge clk); #1;
        end
        lookup_valid = 1'b0;
        load_valid   = 1'b0;
        lookup_last  = 1'b0;
        load_last    = 1'b0;
    endtask

    task automatic expectResult(input logic [31:0] value, input logic [9:0] tag,
                                input logic last, input logic miss);
        result_t r;
        r.value = value;
        r.tag   = tag;
        r.last  = last;
        r.miss  = miss;
        exp_q.push_back(r);
    endtask

    task automatic drainCompare();
        int waited = 0;
        result_t e;
        result_t g;
        while (got_q.size() < exp_q.size() && waited < 500) begin
            @(posedge clk); #1;
            waited++;
        end
        repeat (4) begin
            @(posedge clk); #1;
        end
        checkOutput("out_count", 64'(got_q.size()), 64'(exp_q.size()));
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            checkOutput("out_data", 64'(g.value), 64'(e.value));
            checkOutput("out_tag",  64'(g.tag),   64'(e.tag));
            checkOutput("out_last", 64'(g.last),  64'(e.last));
            checkOutput("out_miss", 64'(g.miss),  64'(e.miss));
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic waitForLoad();
        int waited = 0;
        while (state_o != 2'd0 && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        checkOutput("state_back_to_load", 64'(state_o), 64'd0);
    endtask

    initial begin
        int n;
        bit accepted_now;

        // ---------------- reset ----------------
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("reset_state",   64'(state_o),      64'd0);
        checkOutput("reset_entries", 64'(entries_o),    64'd0);
        checkOutput("reset_err",     64'(err_o),        64'd0);
        checkOutput("reset_valid",   64'(out_valid),    64'd0);
        checkOutput("reset_ldrdy",   64'(load_ready),   64'd1);
        checkOutput("reset_lkrdy",   64'(lookup_ready), 64'd0);

        // ---------------- sequential load 0..7 = 100..107 ----------------
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b0, 16'hFFFF, 32'(100 + i), (i == 7));
        end
        checkOutput("seq_entries", 64'(entries_o),  64'd8);
        checkOutput("seq_state",   64'(state_o),    64'd1);
        checkOutput("seq_ldrdy",   64'(load_ready), 64'd0);
        checkOutput("seq_err",     64'(err_o),      64'd0);

        // ---------------- latency of the first lookup ----------------
        applyStimulus(1'b1, 1'b0, 16'd3, 32'd1, 1'b0);
        expectResult(32'd103, 10'd1, 1'b0, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("latency_edge%0d", k), 64'(out_valid), (k == 3) ? 64'd1 : 64'd0);
        end
        applyStimulus(1'b1, 1'b0, 16'd0, 32'd2, 1'b0);
        expectResult(32'd100, 10'd2, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'd7, 32'd3, 1'b0);
        expectResult(32'd107, 10'd3, 1'b0, 1'b0);
        drainCompare();

        // ---------------- misses beyond entries and beyond DEPTH ----------------
        applyStimulus(1'b1, 1'b0, 16'd8, 32'd4, 1'b0);
        expectResult(32'd0, 10'd4, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 16'd5000, 32'd5, 1'b0);
        expectResult(32'd0, 10'd5, 1'b0, 1'b1);
        drainCompare();

        // ---------------- backpressure: credit limit of 8 ----------------
        out_ready    = 1'b0;
        n            = 0;
        lookup_id    = 16'd0;
        lookup_tag   = 10'd20;
        lookup_valid = 1'b1;
        repeat (20) begin
            accepted_now = lookup_ready;
            @(posedge clk); #1;
            if (accepted_now) begin
                expectResult(32'(100 + (n % 8)), 10'(20 + n), 1'b0, 1'b0);
                n++;
                lookup_id  = 16'(n % 8);
                lookup_tag = 10'(20 + n);
            end
        end
        lookup_valid = 1'b0;
        checkOutput("bp_accepted", 64'(n), 64'd8);
        checkOutput("bp_lkrdy",    64'(lookup_ready), 64'd0);
        checkOutput("bp_held",     64'(out_valid), 64'd1);
        checkOutput("bp_head_tag", 64'(out_tag), 64'd20);
        out_ready = 1'b1;
        drainCompare();

        // ---------------- lookup_last -> DRAIN -> LOAD ----------------
        out_ready = 1'b0;
        applyStimulus(1'b1, 1'b0, 16'd1, 32'd40, 1'b0);
        expectResult(32'd101, 10'd40, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'd2, 32'd41, 1'b0);
        expectResult(32'd102, 10'd41, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'd4, 32'd42, 1'b0);
        expectResult(32'd104, 10'd42, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'd6, 32'd43, 1'b1);
        expectResult(32'd106, 10'd43, 1'b1, 1'b0);
        checkOutput("drain_state", 64'(state_o), 64'd2);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("drain_hold",  64'(state_o),      64'd2);
        checkOutput("drain_lkrdy", 64'(lookup_ready), 64'd0);
        checkOutput("drain_ldrdy", 64'(load_ready),   64'd0);
        out_ready = 1'b1;
        drainCompare();
        waitForLoad();
        checkOutput("reload_entries", 64'(entries_o), 64'd0);
        checkOutput("reload_ldrdy",   64'(load_ready), 64'd1);

        // ---------------- mixed load: 2 seq beats, then addressed ----------------
        applyStimulus(1'b0, 1'b0, 16'hFFFF, 32'd200, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'hFFFF, 32'd201, 1'b0);
        checkOutput("two_beat_entries", 64'(entries_o), 64'd2);
        checkOutput("two_beat_state",   64'(state_o),   64'd0);
        applyStimulus(1'b0, 1'b1, 16'd10, 32'h000000AA, 1'b0);
        checkOutput("addr_err_clear", 64'(err_o), 64'd0);
        applyStimulus(1'b0, 1'b1, 16'd4096, 32'h000000BB, 1'b1);
        checkOutput("addr_err",     64'(err_o),     64'd1);
        checkOutput("addr_entries", 64'(entries_o), 64'd11);
        checkOutput("addr_state",   64'(state_o),   64'd1);

        applyStimulus(1'b1, 1'b0, 16'd10, 32'd50, 1'b0);
        expectResult(32'h000000AA, 10'd50, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'd5, 32'd51, 1'b0);
`ifdef DICT_VALID_BITMAP_EN
        expectResult(32'd0, 10'd51, 1'b0, 1'b1);
`else
        expectResult(32'd105, 10'd51, 1'b0, 1'b0);
`endif
        applyStimulus(1'b1, 1'b0, 16'd1, 32'd52, 1'b0);
        expectResult(32'd201, 10'd52, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'd11, 32'd53, 1'b0);
        expectResult(32'd0, 10'd53, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 16'd4096, 32'd54, 1'b0);
        expectResult(32'd0, 10'd54, 1'b0, 1'b1);
        drainCompare();

        // ---------------- reset with lookups in flight ----------------
        out_ready = 1'b0;
        applyStimulus(1'b1, 1'b0, 16'd0, 32'd60, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'd1, 32'd61, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'd10, 32'd62, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("rst_valid",   64'(out_valid), 64'd0);
        checkOutput("rst_state",   64'(state_o),   64'd0);
        checkOutput("rst_entries", 64'(entries_o), 64'd0);
        checkOutput("rst_err",     64'(err_o),     64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        got_q.delete();
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        checkOutput("rst_no_ghost", 64'(got_q.size()), 64'd0);
        checkOutput("rst_lkrdy",    64'(lookup_ready), 64'd0);

        // ---------------- short phase after reset ----------------
        applyStimulus(1'b0, 1'b0, 16'hFFFF, 32'h00000055, 1'b1);
        checkOutput("post_rst_entries", 64'(entries_o), 64'd1);
        applyStimulus(1'b1, 1'b0, 16'd0, 32'd70, 1'b1);
        expectResult(32'h00000055, 10'd70, 1'b1, 1'b0);
        drainCompare();
        waitForLoad();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
